// File: rtl/battleship_turn_controller_if.sv
// Probe bus between the turn controller and the board store.
interface battleship_turn_controller_if;
    logic       board_req;
    logic [3:0] board_x;
    logic [3:0] board_y;
    logic       board_ack;
    logic [2:0] board_ship;

    modport master (output board_req, board_x, board_y, input board_ack, board_ship);
    modport slave  (input board_req, board_x, board_y, output board_ack, board_ship);
endinterface

// File: rtl/battleship_turn_controller.sv
// Battleship turn controller: synchronizes the score key, probes the board and scores a shot.
// Optional big-bomb (3x3) shots are enabled by defining BATTLESHIP_BIG_BOMB_EN.
module battleship_turn_controller (
    input  logic                                clock,
    input  logic                                reset_L,
    input  logic                                score_L,
    input  logic [3:0]                          x,
    input  logic [3:0]                          y,
    input  logic                                big,
    battleship_turn_controller_if.master        board,
    output logic                                hit_led,
    output logic                                near_led,
    output logic                                miss_led,
    output logic [3:0]                          num_hits,
    output logic [2:0]                          biggest_ship,
    output logic [1:0]                          big_left,
    output logic                                wrong,
    output logic                                busy
);
`ifdef BATTLESHIP_BIG_BOMB_EN
    localparam bit BIG_EN = 1'b1;
`else
    localparam bit BIG_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CHECK, PROBE, WAIT, RESULT, REJECT} state_t;
    state_t state, state_nx;

    logic [2:0] sync;
    logic       start;
    logic [3:0] cx, cy, idx, last_idx, px, py;
    logic [1:0] row;
    logic [3:0] col;
    logic       cbig, turn_hit, turn_near;
    logic       in_board, counted, shot_ok, done;

    // sync[1:0] is the two-flop synchronizer, sync[2] remembers the last synchronized level
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) sync <= 3'b111;
        else          sync <= {sync[1:0], score_L};
    end
    assign start = sync[2] & ~sync[1];

    // Probe cell for the current list index
    always_comb begin
        row = (idx >= 4'd6) ? 2'd2 : (idx >= 4'd3) ? 2'd1 : 2'd0;
        col = idx - ((row == 2'd2) ? 4'd6 : (row == 2'd1) ? 4'd3 : 4'd0);
        px  = cx;
        py  = cy;
        if (cbig) begin
            px = cx + col - 4'd1;
            py = cy + {2'b00, row} - 4'd1;
        end else begin
            case (idx)
                4'd1:    py = cy - 4'd1;
                4'd2:    py = cy + 4'd1;
                4'd3:    px = cx - 4'd1;
                4'd4:    px = cx + 4'd1;
                default: ;
            endcase
        end
    end

    assign in_board = (px >= 4'd1) && (px <= 4'd10) && (py >= 4'd1) && (py <= 4'd10);
    assign counted  = cbig || (idx == 4'd0);
    assign last_idx = cbig ? 4'd8 : 4'd4;
    assign done     = (idx == last_idx) || (!cbig && idx == 4'd0 && turn_hit);
    assign shot_ok  = (cx >= 4'd1) && (cx <= 4'd10) && (cy >= 4'd1) && (cy <= 4'd10)
                      && !(cbig && big_left == 2'd0);

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        busy            = (state != IDLE);
        board.board_req = 1'b0;
        board.board_x   = 4'd0;
        board.board_y   = 4'd0;
        case (state)
            IDLE:   if (start) state_nx = CHECK;
            CHECK:  state_nx = shot_ok ? PROBE : REJECT;
            PROBE: begin
                // Off-board cells are skipped without touching the bus
                if (in_board) begin
                    board.board_req = 1'b1;
                    board.board_x   = px;
                    board.board_y   = py;
                    if (board.board_ack) state_nx = WAIT;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT:   state_nx = done ? RESULT : PROBE;
            RESULT: state_nx = IDLE;
            REJECT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cx <= 4'd0; cy <= 4'd0; cbig <= 1'b0; idx <= 4'd0;
            turn_hit <= 1'b0; turn_near <= 1'b0;
            hit_led <= 1'b0; near_led <= 1'b0; miss_led <= 1'b0;
            num_hits <= 4'd0; biggest_ship <= 3'd0; wrong <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cx   <= x;
                    cy   <= y;
                    cbig <= big & BIG_EN;
                end
                CHECK: if (shot_ok) begin
                    wrong <= 1'b0;
                    hit_led <= 1'b0; near_led <= 1'b0; miss_led <= 1'b0;
                    idx <= 4'd0; turn_hit <= 1'b0; turn_near <= 1'b0;
                end
                REJECT: wrong <= 1'b1;
                PROBE: if (in_board && board.board_ack && board.board_ship != 3'd0) begin
                    if (counted) begin
                        turn_hit <= 1'b1;
                        if (num_hits != 4'd9) num_hits <= num_hits + 4'd1;
                        if (board.board_ship > biggest_ship) biggest_ship <= board.board_ship;
                    end else begin
                        turn_near <= 1'b1;
                    end
                end
                WAIT: if (done) begin
                    hit_led  <= turn_hit;
                    near_led <= !turn_hit && turn_near;
                    miss_led <= !turn_hit && !turn_near;
                end else begin
                    idx <= idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef BATTLESHIP_BIG_BOMB_EN
    logic [1:0] big_left_q;
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L)                           big_left_q <= 2'd2;
        else if (state == WAIT && done && cbig) big_left_q <= big_left_q - 2'd1;
    end
    assign big_left = big_left_q;
`else
    assign big_left = 2'd0;
`endif
endmodule

// File: tb/tb_battleship_turn_controller.sv
// Randomized bench for battleship_turn_controller against a cell-list reference model.
module tb_battleship_turn_controller;
`ifdef BATTLESHIP_BIG_BOMB_EN
    localparam bit BIG_EN = 1'b1;
`else
    localparam bit BIG_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_L, score_L, big;
    logic [3:0] x, y;
    logic       hit_led, near_led, miss_led, wrong, busy;
    logic [3:0] num_hits;
    logic [2:0] biggest_ship;
    logic [1:0] big_left;

    battleship_turn_controller_if bif();

    battleship_turn_controller dut (
        .clock(clock), .reset_L(reset_L), .score_L(score_L), .x(x), .y(y), .big(big),
        .board(bif.master), .hit_led(hit_led), .near_led(near_led), .miss_led(miss_led),
        .num_hits(num_hits), .biggest_ship(biggest_ship), .big_left(big_left),
        .wrong(wrong), .busy(busy)
    );

    always #5 clock = ~clock;

    // Board store model
    logic [2:0] board [0:15][0:15];
    logic       ack_en = 1'b1;
    bit         slow = 1'b0;
    assign bif.board_ack  = bif.board_req & ack_en;
    assign bif.board_ship = board[bif.board_x][bif.board_y];
    always @(negedge clock) ack_en <= slow ? 1'($urandom_range(0, 1)) : 1'b1;

    logic [7:0] probe_q[$];
    int         proto_err = 0;
    int         turns = 0;
    logic       prev_hs = 1'b0, busy_d = 1'b0;
    always @(posedge clock) begin
        if (bif.board_req && bif.board_ack) probe_q.push_back({bif.board_x, bif.board_y});
        if (bif.board_req && prev_hs) proto_err <= proto_err + 1;
        prev_hs <= bif.board_req && bif.board_ack;
        busy_d  <= busy;
        if (busy && !busy_d) turns <= turns + 1;
    end

    int checks = 0, errors = 0;
    int m_hits, m_big, m_left;
    bit m_wrong, m_hit, m_near, m_miss;
    logic [7:0] exp_q[$];
    int lat_hit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit inb(input int a, input int b);
        return a >= 1 && a <= 10 && b >= 1 && b <= 10;
    endfunction

    task automatic model_reset();
        m_hits = 0; m_big = 0; m_left = BIG_EN ? 2 : 0;
        m_wrong = 0; m_hit = 0; m_near = 0; m_miss = 0;
    endtask

    // Expected probe list and score for one shot, from the shot rules
    task automatic model_shot(input int sx, input int sy, input bit sb);
        bit be, h, n;
        int cnt;
        int ndx[4] = '{0, 0, -1, 1};
        int ndy[4] = '{-1, 1, 0, 0};
        exp_q.delete();
        be = sb && BIG_EN;
        if (!inb(sx, sy) || (be && m_left == 0)) begin
            m_wrong = 1;
            return;
        end
        m_wrong = 0; cnt = 0; h = 0; n = 0;
        if (be) begin
            for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++)
                    if (inb(sx + dx, sy + dy)) begin
                        exp_q.push_back({4'(sx + dx), 4'(sy + dy)});
                        if (board[sx + dx][sy + dy] != 0) begin
                            cnt++; h = 1;
                            if (board[sx + dx][sy + dy] > m_big) m_big = board[sx + dx][sy + dy];
                        end
                    end
            m_left--;
        end else begin
            exp_q.push_back({4'(sx), 4'(sy)});
            if (board[sx][sy] != 0) begin
                cnt = 1; h = 1;
                if (board[sx][sy] > m_big) m_big = board[sx][sy];
            end else begin
                for (int k = 0; k < 4; k++)
                    if (inb(sx + ndx[k], sy + ndy[k])) begin
                        exp_q.push_back({4'(sx + ndx[k]), 4'(sy + ndy[k])});
                        if (board[sx + ndx[k]][sy + ndy[k]] != 0) n = 1;
                    end
            end
        end
        m_hits = (m_hits + cnt > 9) ? 9 : m_hits + cnt;
        m_hit = h; m_near = !h && n; m_miss = !h && !n;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".hit"}, hit_led, m_hit);
        check({tag, ".near"}, near_led, m_near);
        check({tag, ".miss"}, miss_led, m_miss);
        check({tag, ".wrong"}, wrong, m_wrong);
        check({tag, ".num_hits"}, num_hits, m_hits);
        check({tag, ".biggest"}, biggest_ship, m_big);
        check({tag, ".big_left"}, big_left, m_left);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".nprobes"}, probe_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < probe_q.size(); i++)
            check({tag, ".probe"}, probe_q[i], exp_q[i]);
    endtask

    task automatic clear_board();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) board[i][j] = 3'd0;
    endtask

    task automatic random_board();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                board[i][j] = (inb(i, j) && $urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 5)) : 3'd0;
    endtask

    task automatic do_shot(input string tag, input int sx, input int sy, input bit sb, input bit hold);
        bit seen, done;
        probe_q.delete();
        @(negedge clock);
        x = 4'(sx); y = 4'(sy); big = sb; score_L = 1'b0;
        lat_hit = -1; seen = 0; done = 0;
        for (int c = 1; c <= 400 && !done; c++) begin
            @(negedge clock);
            if (hit_led && lat_hit < 0) lat_hit = c;
            if (busy) begin
                // Captured operands must not follow later input changes
                if (!seen) begin
                    x = 4'($urandom); y = 4'($urandom); big = 1'($urandom);
                end
                seen = 1;
            end else if (seen) begin
                done = 1;
            end
        end
        check({tag, ".turn_done"}, done, 1);
        if (!hold) score_L = 1'b1;
        repeat (4) @(negedge clock);
        model_shot(sx, sy, sb);
        check_state(tag);
    endtask

    initial begin
        int t0, sx, sy;
        bit seen;
        reset_L = 1'b0; score_L = 1'b1; x = 4'd0; y = 4'd0; big = 1'b0;
        clear_board();
        model_reset();
        repeat (3) @(negedge clock);
        check("rst.req", bif.board_req, 0);
        check("rst.bx", bif.board_x, 0);
        check("rst.by", bif.board_y, 0);
        check_state("rst");
        reset_L = 1'b1;
        repeat (2) @(negedge clock);

        // Center hit with immediate ack: result four cycles after the start pulse
        board[3][3] = 3'd4;
        do_shot("hit33", 3, 3, 0, 0);
        check("hit33.latency", lat_hit, 6);

        // Illegal coordinate: rejected, nothing probed, LEDs kept
        do_shot("rej05", 0, 5, 0, 0);
        do_shot("rej_b", 11, 4, 0, 0);
        do_shot("after_rej", 7, 8, 0, 0);

        // Corner shot, water center, ship east
        clear_board();
        board[2][1] = 3'd2;
        do_shot("near11", 1, 1, 0, 0);

`ifdef BATTLESHIP_BIG_BOMB_EN
        clear_board();
        board[4][6] = 3'd3;
        for (int i = 0; i < 4; i++) do_shot("big55", 5, 5, 1, 0);
        check("big.exhausted", big_left, 0);
        check("big.wrong", wrong, 1);
`else
        clear_board();
        board[2][2] = 3'd5;
        do_shot("big_ignored", 3, 3, 1, 0);
`endif

        // Ten hits saturate the counter
        clear_board();
        for (int i = 0; i < 10; i++) begin
            sx = $urandom_range(1, 10); sy = $urandom_range(1, 10);
            board[sx][sy] = 3'($urandom_range(1, 5));
            do_shot("sat", sx, sy, 0, 0);
        end
        check("sat.num_hits", num_hits, 9);

        // Held key starts only one turn
        t0 = turns;
        do_shot("held", 6, 6, 0, 1);
        repeat (30) @(negedge clock);
        check("held.turns", turns - t0, 1);
        score_L = 1'b1;
        repeat (4) @(negedge clock);

        // Reset pulsed in the gap after an acknowledged probe
        random_board();
        board[5][5] = 3'd2;
        @(negedge clock);
        x = 4'd5; y = 4'd5; big = 1'b0; score_L = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            if (bif.board_req) seen = 1;
        end
        check("rstwait.req_seen", seen, 1);
        @(negedge clock);
        reset_L = 1'b0;
        #1;
        model_reset();
        probe_q.delete(); exp_q.delete();
        check("rstwait.req", bif.board_req, 0);
        check_state("rstwait");
        score_L = 1'b1;
        @(negedge clock);
        reset_L = 1'b1;
        repeat (4) @(negedge clock);

        // Randomized shots, boards and ack timing
        for (int i = 0; i < 40; i++) begin
            random_board();
            slow = 1'($urandom_range(0, 1));
            do_shot("rand", $urandom_range(0, 11), $urandom_range(0, 11), 1'($urandom_range(0, 1)), 0);
        end
        slow = 1'b0;

        check("protocol", proto_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
